// File: rtl/color_pkg.sv
// Shared definitions for the colour-sensor front end and its downstream classifier.
package color_pkg;

    localparam int unsigned GATE_CYCLES_DEF = 12_500_000;
    localparam int unsigned SHIFT_DEF       = 3;

    typedef enum logic [1:0] {
        FILT_RED   = 2'b00,
        FILT_BLUE  = 2'b01,
        FILT_GREEN = 2'b11
    } filter_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_PUBLISH
    } state_e;

    // Fixed measurement order: RED -> BLUE -> GREEN -> RED.
    function automatic filter_e next_filter(input filter_e f);
        case (f)
            FILT_RED:  return FILT_BLUE;
            FILT_BLUE: return FILT_GREEN;
            default:   return FILT_RED;
        endcase
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for the sensor square wave plus a rising-edge pulse.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise_c
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= i_async;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_rise_c = r_s2 & ~r_prev;

endmodule

// File: rtl/tcs_freq_sampler.sv
// Colour-sensor front end: steps the filter through RED/BLUE/GREEN, counts sensor
// edges over a gate window per filter and publishes the scaled frame at once.
module tcs_freq_sampler
    import color_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = GATE_CYCLES_DEF,
    parameter int unsigned SETTLE_CYCLES = 100_000,
    parameter int unsigned CNT_W         = 25,
    parameter int unsigned SHIFT         = SHIFT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             freq_in,
    output logic             select0,
    output logic             select1,
    output logic             select2,
    output logic             select3,
    output logic             EO,
    output logic [CNT_W-1:0] red,
    output logic [CNT_W-1:0] green,
    output logic [CNT_W-1:0] blue,
    output logic             sample_valid,
    output logic             overflow
);

    localparam int unsigned TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    state_e            r_state;
    filter_e           r_filt;
    logic [TMR_W-1:0]  r_tmr;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_sh_red;
    logic [CNT_W-1:0]  r_sh_blue;
    logic [CNT_W-1:0]  r_sh_green;
    logic [2:0]        r_sh_ovf;
    logic [CNT_W-1:0]  r_red;
    logic [CNT_W-1:0]  r_green;
    logic [CNT_W-1:0]  r_blue;
    logic              r_valid;
    logic              r_ovf;

    logic              w_rise;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [CNT_W-1:0]  w_shl;
    logic [CNT_W-1:0]  w_scaled;
    logic              w_sat;

    edge_sync u_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .i_async  (freq_in),
        .o_rise_c (w_rise)
    );

    // Saturating edge count including this cycle's edge, and its saturating scale.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_rise && (r_cnt != '1)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
        w_shl    = w_cnt_next << SHIFT;
        w_sat    = ((w_shl >> SHIFT) != w_cnt_next) || (w_cnt_next == '1);
        w_scaled = w_sat ? '1 : w_shl;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_filt     <= FILT_RED;
            r_tmr      <= '0;
            r_cnt      <= '0;
            r_sh_red   <= '0;
            r_sh_blue  <= '0;
            r_sh_green <= '0;
            r_sh_ovf   <= '0;
            r_red      <= '0;
            r_green    <= '0;
            r_blue     <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_filt <= FILT_RED;
                    r_tmr  <= '0;
                    r_cnt  <= '0;
                    if (enable) begin
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                        r_filt  <= FILT_RED;
                    end else if (r_tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
                        r_tmr   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_GATE;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                ST_GATE: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                        r_filt  <= FILT_RED;
                    end else if (r_tmr == TMR_W'(GATE_CYCLES - 1)) begin
                        r_tmr <= '0;
                        r_cnt <= '0;
                        case (r_filt)
                            FILT_RED: begin
                                r_sh_red    <= w_scaled;
                                r_sh_ovf[0] <= w_sat;
                            end
                            FILT_BLUE: begin
                                r_sh_blue   <= w_scaled;
                                r_sh_ovf[1] <= w_sat;
                            end
                            default: begin
                                r_sh_green  <= w_scaled;
                                r_sh_ovf[2] <= w_sat;
                            end
                        endcase
                        r_filt  <= next_filter(r_filt);
                        r_state <= (r_filt == FILT_GREEN) ? ST_PUBLISH : ST_SETTLE;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                        r_cnt <= w_cnt_next;
                    end
                end
                default: begin
                    r_red   <= r_sh_red;
                    r_blue  <= r_sh_blue;
                    r_green <= r_sh_green;
                    r_ovf   <= |r_sh_ovf;
                    r_valid <= 1'b1;
                    r_state <= enable ? ST_SETTLE : ST_IDLE;
                end
            endcase
        end
    end

    assign select0          = 1'b1;
    assign select1          = 1'b0;
    assign {select2, select3} = r_filt;
    assign EO               = 1'b0;
    assign red              = r_red;
    assign green            = r_green;
    assign blue             = r_blue;
    assign sample_valid     = r_valid;
    assign overflow         = r_ovf;

endmodule

// File: tb/tb_tcs_freq_sampler.sv
// Bench for tcs_freq_sampler: directed frames plus randomized input, checked
// against an edge-counting reference model over recorded input history.
module tb_tcs_freq_sampler;

    localparam int G  = 1000;
    localparam int S  = 10;
    localparam int SH = 3;
    localparam int FR = 3 * (S + G) + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        freq_in;
    logic        man_val;
    logic        gen_val;
    int          mode = 0;
    int          per  = 10;
    int          dens = 30;

    logic        sel0, sel1, sel2, sel3, eo, valid, ovf;
    logic [11:0] red, green, blue;
    logic        sel0_b, sel1_b, sel2_b, sel3_b, eo_b, valid_b, ovf_b;
    logic [10:0] red_b, green_b, blue_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit hist [0:65535];
    int last_r, last_g, last_b, last_o;

    assign freq_in = (mode == 0) ? man_val : gen_val;

    tcs_freq_sampler #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(12), .SHIFT(SH)) dut (
        .clk(clk), .rst(rst), .enable(enable), .freq_in(freq_in),
        .select0(sel0), .select1(sel1), .select2(sel2), .select3(sel3), .EO(eo),
        .red(red), .green(green), .blue(blue), .sample_valid(valid), .overflow(ovf)
    );

    tcs_freq_sampler #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(11), .SHIFT(SH)) dut11 (
        .clk(clk), .rst(rst), .enable(enable), .freq_in(freq_in),
        .select0(sel0_b), .select1(sel1_b), .select2(sel2_b), .select3(sel3_b), .EO(eo_b),
        .red(red_b), .green(green_b), .blue(blue_b), .sample_valid(valid_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    // hist[k] is the input value seen at rising edge k.
    always @(posedge clk) begin
        hist[16'(cyc)] <= freq_in;
        cyc            <= cyc + 1;
    end

    // Stimulus generator; at a falling edge cyc is the index of the next rising edge.
    always @(negedge clk) begin
        case (mode)
            1:       gen_val = (cyc % per) < (per / 2);
            2: begin
                if ({sel2, sel3} == 2'b00)      gen_val = (cyc % 20) < 10;
                else if ({sel2, sel3} == 2'b01) gen_val = (cyc % 10) < 5;
                else                            gen_val = (cyc % 5) < 2;
            end
            3:       gen_val = ($urandom_range(0, 99) < dens);
            default: gen_val = 1'b0;
        endcase
    end

    // An input rise seen at edge n-1 is counted if cycle n lies in the channel's gate.
    function automatic int model_count(input int e0, input int ch);
        int n0 = e0 + ch * (S + G) + S;
        int c  = 0;
        for (int n = n0; n < n0 + G; n++) begin
            if (hist[16'(n - 1)] && !hist[16'(n - 2)]) c++;
        end
        return c;
    endfunction

    function automatic int scaled(input int cnt, input int w);
        int lim = (1 << w) - 1;
        int v   = cnt * (1 << SH);
        return (v > lim) ? lim : v;
    endfunction

    function automatic int sat(input int cnt, input int w);
        return (cnt * (1 << SH) > (1 << w) - 1) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int n);
        while ((cyc - 1) < n) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int e0);
        int lim = e0 + FR + 20;
        @(negedge clk);
        while (!valid && ((cyc - 1) < lim)) @(negedge clk);
        check({tag, " valid_cycle"}, 32'(cyc - 1), 32'(e0 + FR));
        check({tag, " valid11"}, 32'(valid_b), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int e0);
        int cr = model_count(e0, 0);
        int cb = model_count(e0, 1);
        int cg = model_count(e0, 2);
        last_r = scaled(cr, 12);
        last_b = scaled(cb, 12);
        last_g = scaled(cg, 12);
        last_o = sat(cr, 12) | sat(cb, 12) | sat(cg, 12);
        check({tag, " red"},     32'(red),     32'(last_r));
        check({tag, " blue"},    32'(blue),    32'(last_b));
        check({tag, " green"},   32'(green),   32'(last_g));
        check({tag, " ovf"},     32'(ovf),     32'(last_o));
        check({tag, " red11"},   32'(red_b),   32'(scaled(cr, 11)));
        check({tag, " blue11"},  32'(blue_b),  32'(scaled(cb, 11)));
        check({tag, " green11"}, 32'(green_b), 32'(scaled(cg, 11)));
        check({tag, " ovf11"},   32'(ovf_b),   32'(sat(cr, 11) | sat(cb, 11) | sat(cg, 11)));
    endtask

    initial begin
        int e0;
        int nvalid;
        rst     = 1'b1;
        enable  = 1'b0;
        man_val = 1'b0;

        // Reset values and constant sensor controls
        repeat (3) @(negedge clk);
        check("rst red",   32'(red),   32'd0);
        check("rst green", 32'(green), 32'd0);
        check("rst blue",  32'(blue),  32'd0);
        check("rst valid", 32'(valid), 32'd0);
        check("rst ovf",   32'(ovf),   32'd0);
        check("rst sel23", 32'({sel2, sel3}), 32'd0);
        check("rst sel01", 32'({sel0, sel1}), 32'd2);
        check("rst eo",    32'(eo),    32'd0);
        check("rst sel11", 32'({sel0_b, sel1_b, sel2_b, sel3_b, eo_b}), 32'b10000);
        check("rst out11", 32'({red_b, green_b, blue_b, valid_b, ovf_b}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Steady input, two back-to-back frames
        mode = 1; per = 10;
        e0 = cyc; enable = 1'b1;
        wait_valid("steady1", e0);
        check_frame("steady1", e0);
        check("steady1 const_red", 32'(red), 32'd800);
        check("steady1 const_grn", 32'(green), 32'd800);
        @(negedge clk);
        check("steady1 pulse_len", 32'(valid), 32'd0);
        e0 = e0 + FR;
        wait_valid("steady2", e0);
        check_frame("steady2", e0);
        check("steady2 const_blu", 32'(blue), 32'd800);

        // Per-channel periods and select sequence
        mode = 2;
        e0 = e0 + FR;
        wait_until(e0 + S + 5);
        check("chan sel_red", 32'({sel2, sel3}), 32'b00);
        wait_until(e0 + (S + G) + S + 5);
        check("chan sel_blue", 32'({sel2, sel3}), 32'b01);
        wait_until(e0 + 2 * (S + G) + S + 5);
        check("chan sel_green", 32'({sel2, sel3}), 32'b11);
        wait_valid("chan", e0);
        check_frame("chan", e0);
        check("chan sel_wrap", 32'({sel2, sel3}), 32'b00);
        check("chan const_red", 32'(red), 32'd400);
        check("chan const_blu", 32'(blue), 32'd800);
        check("chan const_grn", 32'(green), 32'd1600);

        // Saturation: 500 edges per window
        mode = 1; per = 2;
        e0 = e0 + FR;
        wait_valid("sat", e0);
        check_frame("sat", e0);
        check("sat const_red", 32'(red), 32'd4000);
        check("sat const_ovf", 32'(ovf), 32'd0);
        check("sat const_red11", 32'(red_b), 32'd2047);
        check("sat const_ovf11", 32'(ovf_b), 32'd1);

        // Randomized density frame, then randomized period frame
        mode = 3; dens = int'($urandom_range(5, 60));
        e0 = e0 + FR;
        wait_valid("rand_dens", e0);
        check_frame("rand_dens", e0);
        mode = 1; per = int'($urandom_range(2, 40));
        e0 = e0 + FR;
        wait_valid("rand_per", e0);
        check_frame("rand_per", e0);

        // Abort during BLUE gate
        per = 10;
        e0 = e0 + FR;
        wait_until(e0 + (S + G) + S + 500);
        check("abort sel_before", 32'({sel2, sel3}), 32'b01);
        enable = 1'b0;
        @(negedge clk);
        check("abort sel_idle", 32'({sel2, sel3}), 32'b00);
        nvalid = 0;
        for (int i = 0; i < FR + 20; i++) begin
            if (valid) nvalid++;
            @(negedge clk);
        end
        check("abort no_valid", 32'(nvalid), 32'd0);
        check("abort hold_red", 32'(red), 32'(last_r));
        check("abort hold_blu", 32'(blue), 32'(last_b));
        check("abort hold_grn", 32'(green), 32'(last_g));
        check("abort hold_ovf", 32'(ovf), 32'(last_o));

        // Asynchronous reset mid-gate, then a clean frame
        e0 = cyc; enable = 1'b1;
        wait_until(e0 + S + 300);
        #2 rst = 1'b1;
        enable = 1'b0;
        #1;
        check("arst red",   32'(red),   32'd0);
        check("arst green", 32'(green), 32'd0);
        check("arst blue",  32'(blue),  32'd0);
        check("arst ovf",   32'(ovf),   32'd0);
        check("arst sel23", 32'({sel2, sel3}), 32'd0);
        check("arst red11", 32'(red_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        e0 = cyc; enable = 1'b1;
        wait_valid("post_rst", e0);
        check_frame("post_rst", e0);
        check("post_rst const_red", 32'(red), 32'd800);
        check("post_rst const_ovf", 32'(ovf), 32'd0);

        // Single pulses at last SETTLE cycle and last GATE cycle of RED
        enable = 1'b0; mode = 0; man_val = 1'b0;
        repeat (5) @(negedge clk);
        e0 = cyc; enable = 1'b1;
        wait_until(e0 + S - 3);
        man_val = 1'b1;
        @(negedge clk);
        man_val = 1'b0;
        wait_until(e0 + S + G - 3);
        man_val = 1'b1;
        @(negedge clk);
        man_val = 1'b0;
        wait_valid("bound", e0);
        check_frame("bound", e0);
        check("bound const_red", 32'(red), 32'd8);
        check("bound const_blu", 32'(blue), 32'd0);
        check("bound const_grn", 32'(green), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
